// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and divider helper for the parametrised UART
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous first-word-fall-through FIFO for received words
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_push,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - full-duplex UART: 16x oversampled RX, configurable framing, RX FIFO
module uart_param
  import uart_pkg::*;
#(
  parameter int      CLK_HZ        = 50_000_000,
  parameter int      BAUD          = 115_200,
  parameter int      OVERSAMPLE    = 16,
  parameter int      DATA_BITS     = 8,
  parameter parity_e PARITY        = PAR_NONE,
  parameter int      STOP_BITS     = 1,
  parameter int      RX_FIFO_DEPTH = 16
) (
  input  logic                               clk50,
  input  logic                               reset_n,
  input  logic                               uart_rx,
  output logic                               uart_tx,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx_busy,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_parity_err,
  output logic                               rx_frame_err,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0] rx_count,
  output logic                               rx_overrun,
  input  logic                               err_clr
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY != PAR_NONE);

  if (DIV < 1) begin : g_div_chk
    $error("uart_param: clock divider below 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_db_chk
    $error("uart_param: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_param: STOP_BITS must be 1 or 2");
  end

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk50) begin
    if (!reset_n || w_tick) r_div_cnt <= '0;
    else                    r_div_cnt <= r_div_cnt + 1'b1;
  end

  tx_state_e            r_tx_state, w_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx_par, w_tx_par;
  logic [OS_W-1:0]      r_tx_tick, w_tx_tick;
  logic [2:0]           r_tx_bit, w_tx_bit;
  logic                 r_uart_tx, w_tx_line, w_tx_end;

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_shift <= w_tx_shift;
      r_tx_par   <= w_tx_par;
      r_tx_tick  <= w_tx_tick;
      r_tx_bit   <= w_tx_bit;
      r_uart_tx  <= w_tx_line;
    end
  end

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_shift = r_tx_shift;
    w_tx_par   = r_tx_par;
    w_tx_tick  = r_tx_tick;
    w_tx_bit   = r_tx_bit;
    w_tx_line  = 1'b1;
    w_tx_end   = w_tick && (r_tx_tick == OS_LAST);
    if (w_tick) w_tx_tick = w_tx_end ? '0 : r_tx_tick + 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_tick = '0;
        w_tx_bit  = '0;
        if (tx_valid) begin
          w_tx_state = TX_START;
          w_tx_shift = tx_data;
          w_tx_par   = par_bit(tx_data);
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) w_tx_state = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_end) begin
          w_tx_shift = r_tx_shift >> 1;
          w_tx_bit   = r_tx_bit + 1'b1;
          if (r_tx_bit == DATA_LAST) begin
            w_tx_bit   = '0;
            w_tx_state = HAS_PAR ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_end) w_tx_state = TX_STOP;
      end
      TX_STOP: begin
        if (w_tx_end) begin
          w_tx_bit = r_tx_bit + 1'b1;
          if (r_tx_bit == STOP_LAST) begin
            w_tx_bit   = '0;
            w_tx_state = TX_IDLE;
          end
        end
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  assign uart_tx  = r_uart_tx;
  assign tx_ready = (r_tx_state == TX_IDLE);
  assign tx_busy  = ~tx_ready;

  logic                 r_rx_s1, r_rx_s2;
  rx_state_e            r_rx_state, w_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  logic                 r_rx_par, w_rx_par;
  logic [OS_W-1:0]      r_rx_tick, w_rx_tick;
  logic [2:0]           r_rx_bit, w_rx_bit;
  logic                 w_rx_samp, w_rx_push;
  logic [DATA_BITS+1:0] w_rx_word, w_head;
  logic                 w_full, w_empty;

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state;
      r_rx_shift <= w_rx_shift;
      r_rx_par   <= w_rx_par;
      r_rx_tick  <= w_rx_tick;
      r_rx_bit   <= w_rx_bit;
    end
  end

  // Samples land mid-bit: half a bit after the start edge, then one bit apart.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_shift = r_rx_shift;
    w_rx_par   = r_rx_par;
    w_rx_tick  = r_rx_tick;
    w_rx_bit   = r_rx_bit;
    w_rx_push  = 1'b0;
    w_rx_samp  = w_tick && (r_rx_tick == OS_LAST);
    if (w_tick) w_rx_tick = w_rx_samp ? '0 : r_rx_tick + 1'b1;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_tick = '0;
        w_rx_bit  = '0;
        if (w_tick && !r_rx_s2) w_rx_state = RX_START;
      end
      RX_START: begin
        if (w_tick && r_rx_tick == OS_HALF) begin
          w_rx_tick  = '0;
          w_rx_state = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_samp) begin
          w_rx_shift = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
          w_rx_bit   = r_rx_bit + 1'b1;
          if (r_rx_bit == DATA_LAST) begin
            w_rx_bit   = '0;
            w_rx_state = HAS_PAR ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_samp) begin
          w_rx_par   = r_rx_s2;
          w_rx_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_samp) begin
          w_rx_push  = 1'b1;
          w_rx_state = RX_IDLE;
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  assign w_rx_word = {~r_rx_s2, HAS_PAR && (par_bit(r_rx_shift) != r_rx_par), r_rx_shift};

  uart_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk50),
    .reset_n   (reset_n),
    .i_wr_data (w_rx_word),
    .i_push    (w_rx_push),
    .i_pop     (rx_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (rx_count)
  );

  assign {rx_frame_err, rx_parity_err, rx_data} = w_head;
  assign rx_valid = ~w_empty;

  logic r_overrun;

  always_ff @(posedge clk50) begin
    if (!reset_n)                          r_overrun <= 1'b0;
    else if (w_rx_push && w_full && !rx_ready) r_overrun <= 1'b1;
    else if (err_clr)                      r_overrun <= 1'b0;
  end

  assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - directed self-checking bench for uart_param (8N1, 8E1 loopback, 7O2)
module tb_uart_param;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic ser_line = 1'b1;
  logic line_sel = 1'b0;

  logic       a_rx, a_tx, a_tx_ready, a_tx_busy, a_perr, a_ferr, a_rx_valid, a_ovr;
  logic [7:0] a_tx_data = 8'h00, a_rx_data;
  logic       a_tx_valid = 1'b0, a_rx_ready = 1'b0, a_err_clr = 1'b0;
  logic [4:0] a_rx_count;

  logic       b_tx, b_tx_ready, b_tx_busy, b_perr, b_ferr, b_rx_valid, b_ovr;
  logic [7:0] b_tx_data = 8'h00, b_rx_data;
  logic       b_tx_valid = 1'b0, b_rx_ready = 1'b0, b_err_clr = 1'b0;
  logic [4:0] b_rx_count;

  logic       c_rx, c_tx, c_tx_ready, c_tx_busy, c_perr, c_ferr, c_rx_valid, c_ovr;
  logic [6:0] c_tx_data = 7'h00, c_rx_data;
  logic       c_tx_valid = 1'b0, c_rx_ready = 1'b0, c_err_clr = 1'b0;
  logic [4:0] c_rx_count;

  assign a_rx = line_sel ? 1'b1 : ser_line;
  assign c_rx = line_sel ? ser_line : 1'b1;

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(PAR_NONE), .STOP_BITS(1), .RX_FIFO_DEPTH(16)) u_a (
    .clk50(clk), .reset_n(reset_n), .uart_rx(a_rx), .uart_tx(a_tx),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_busy(a_tx_busy),
    .rx_data(a_rx_data), .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_valid(a_rx_valid),
    .rx_ready(a_rx_ready), .rx_count(a_rx_count), .rx_overrun(a_ovr), .err_clr(a_err_clr));

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(PAR_EVEN), .STOP_BITS(1), .RX_FIFO_DEPTH(16)) u_b (
    .clk50(clk), .reset_n(reset_n), .uart_rx(b_tx), .uart_tx(b_tx),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_busy(b_tx_busy),
    .rx_data(b_rx_data), .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .rx_count(b_rx_count), .rx_overrun(b_ovr), .err_clr(b_err_clr));

  uart_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(7),
               .PARITY(PAR_ODD), .STOP_BITS(2), .RX_FIFO_DEPTH(16)) u_c (
    .clk50(clk), .reset_n(reset_n), .uart_rx(c_rx), .uart_tx(c_tx),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready), .tx_busy(c_tx_busy),
    .rx_data(c_rx_data), .rx_parity_err(c_perr), .rx_frame_err(c_ferr), .rx_valid(c_rx_valid),
    .rx_ready(c_rx_ready), .rx_count(c_rx_count), .rx_overrun(c_ovr), .err_clr(c_err_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_line = b;
    repeat (16) @(negedge clk);
  endtask

  // par < 0 means no parity bit; stop_val is the first stop bit's level.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                            input logic stop_val, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
    send_bit(stop_val);
    for (int i = 1; i < nstop; i++) send_bit(1'b1);
    ser_line = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_a();
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
  endtask

  task automatic tx_a5_test();
    int n_rdy, n_low, guard;
    logic [7:0] got;
    logic stop_s;
    @(negedge clk);
    a_tx_data  = 8'hA5;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    fork
      begin
        n_rdy = 0;
        while (!a_tx_ready && n_rdy < 400) begin n_rdy++; @(negedge clk); end
      end
      begin
        guard = 0;
        while (a_tx && guard < 20) begin guard++; @(negedge clk); end
        n_low = 0;
        while (!a_tx && n_low < 40) begin n_low++; @(negedge clk); end
        repeat (8) @(negedge clk);
        got[0] = a_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (16) @(negedge clk);
          got[i] = a_tx;
        end
        repeat (16) @(negedge clk);
        stop_s = a_tx;
      end
    join
    chk("tx_start_len", n_low, 16);
    chk("tx_data_bits", got, 8'hA5);
    chk("tx_stop", stop_s, 1);
    chk("tx_ready_low", n_rdy, 160);
  endtask

  task automatic loopback_test();
    int g, h;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          g = 0;
          while (!b_tx_ready && g < 1000) begin g++; @(negedge clk); end
          b_tx_data  = 8'(i);
          b_tx_valid = 1'b1;
          @(negedge clk);
          b_tx_valid = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 256; j++) begin
          h = 0;
          while (!b_rx_valid && h < 1000) begin h++; @(negedge clk); end
          chk("loop_valid", b_rx_valid, 1);
          chk("loop_word", {b_ferr, b_perr, b_rx_data}, {2'b00, 8'(j)});
          b_rx_ready = 1'b1;
          @(negedge clk);
          b_rx_ready = 1'b0;
        end
      end
    join
    chk("loop_count_end", b_rx_count, 0);
    chk("loop_ovr_end", b_ovr, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a_tx", a_tx, 1);
    chk("rst_a_ready", a_tx_ready, 1);
    chk("rst_a_busy", a_tx_busy, 0);
    chk("rst_a_rxvalid", a_rx_valid, 0);
    chk("rst_a_count", a_rx_count, 0);
    chk("rst_a_ovr", a_ovr, 0);
    chk("rst_a_head", {a_ferr, a_perr, a_rx_data}, 0);
    chk("rst_b_busy", b_tx_busy, 0);
    chk("rst_c_tx", c_tx, 1);
    chk("rst_c_ready", c_tx_ready, 1);
    chk("rst_c_busy", c_tx_busy, 0);
    chk("rst_c_ovr", c_ovr, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_a5_test();
    loopback_test();

    line_sel = 1'b1;
    send_frame(8'h55, 7, 0, 1'b1, 2);
    chk("c_badpar_count", c_rx_count, 1);
    chk("c_badpar_word", {c_ferr, c_perr, c_rx_data}, {2'b01, 7'h55});
    c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;
    send_frame(8'h13, 7, 0, 1'b1, 2);
    chk("c_goodpar_word", {c_ferr, c_perr, c_rx_data}, {2'b00, 7'h13});
    c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;
    chk("c_count_end", c_rx_count, 0);
    line_sel = 1'b0;

    send_frame(8'h3C, 8, -1, 1'b0, 1);
    chk("ferr_count", a_rx_count, 1);
    chk("ferr_word", {a_ferr, a_perr, a_rx_data}, {2'b10, 8'h3C});
    pop_a();
    send_frame(8'h00, 8, -1, 1'b0, 1);
    chk("break_count", a_rx_count, 1);
    chk("break_word", {a_ferr, a_perr, a_rx_data}, {2'b10, 8'h00});
    pop_a();
    chk("break_popped", a_rx_valid, 0);

    for (int i = 0; i < 17; i++) send_frame(8'(i * 13 + 5), 8, -1, 1'b1, 1);
    chk("ovr_count", a_rx_count, 16);
    chk("ovr_flag", a_ovr, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovr_word", {a_rx_valid, a_ferr, a_perr, a_rx_data}, {3'b100, 8'(i * 13 + 5)});
      pop_a();
    end
    chk("ovr_drained", a_rx_count, 0);
    chk("ovr_sticky", a_ovr, 1);
    a_err_clr = 1'b1; @(negedge clk); a_err_clr = 1'b0;
    chk("ovr_cleared", a_ovr, 0);

    ser_line = 1'b0;
    repeat (8) @(negedge clk);
    ser_line = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", a_rx_count, 0);
    chk("glitch_valid", a_rx_valid, 0);

    a_tx_data  = 8'h00;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("midtx_line_low", a_tx, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midtx_rst_tx", a_tx, 1);
    chk("midtx_rst_ready", a_tx_ready, 1);
    chk("midtx_rst_busy", a_tx_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
